// File: rtl/lcd_8080_pkg.sv
// Shared constants and types for the 8080-bus receiver: opcodes, parser states, panel defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lcd_8080_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   // Panel power-on address window (240 x 320)
   localparam logic [15:0] DEF_COL_START  = 16'd0;
   localparam logic [15:0] DEF_COL_END    = 16'd239;
   localparam logic [15:0] DEF_PAGE_START = 16'd0;
   localparam logic [15:0] DEF_PAGE_END   = 16'd319;

   // Record layout: {is_cmd, d[15:0]}
   localparam int REC_W = 17;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PARAM,
      ST_PIXELS
   } parse_state_e;

   // Inclusive span of an address range; an inverted range has no pixels.
   function automatic logic [16:0] span_len(input logic [15:0] s, input logic [15:0] e);
      if (e < s) return 17'd0;
      return {1'b0, e} - {1'b0, s} + 17'd1;
   endfunction

endpackage

// File: rtl/lcd_8080_receiver_if.sv
// 8080 write bus plus the decoded-record valid/ready stream.
// Latency: n/a (wiring only).
// Backpressure: rec_ready from the consumer holds rec_data/rec_valid.
// master: LCD controller / record consumer side; slave: the receiver.
interface lcd_8080_receiver_if;
   import lcd_8080_pkg::*;

   logic             lcd_csx;
   logic             lcd_dcx;
   logic             lcd_wrx;
   logic [15:0]      lcd_d;
   logic             lcd_resx;
   logic             rec_valid;
   logic             rec_ready;
   logic [REC_W-1:0] rec_data;

   modport master (
      output lcd_csx, lcd_dcx, lcd_wrx, lcd_d, lcd_resx, rec_ready,
      input  rec_valid, rec_data
   );

   modport slave (
      input  lcd_csx, lcd_dcx, lcd_wrx, lcd_d, lcd_resx, rec_ready,
      output rec_valid, rec_data
   );

endinterface

// File: rtl/lcd_rec_fifo.sv
// Synchronous record FIFO with registered head (vld_o/dat_o) and full/empty flags.
// Latency: a push into an empty FIFO is visible on vld_o/dat_o the cycle after the push.
// Backpressure: pop_i only when vld_o; a push while full is refused unless a pop happens the same cycle.
// Ports: clk/reset, push_i/push_dat_i, pop_i, full_o, empty_o, vld_o, dat_o.
module lcd_rec_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic             vld_o,
   output logic [WIDTH-1:0] dat_o
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             vld_q, vld_d;
   logic [WIDTH-1:0] dat_q, dat_d;
   logic             pop_ok, push_ok;

   always_comb begin
      pop_ok   = pop_i && (cnt_q != '0);
      push_ok  = push_i && ((cnt_q != CNT_FULL) || pop_ok);
      rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_ONE;
      else if (!push_ok && pop_ok) cnt_d = cnt_q - CNT_ONE;
      vld_d = (cnt_d != '0);
      // The next head is the word being written only when it lands in the
      // slot the read pointer will point at (FIFO holding exactly one entry).
      dat_d = dat_q;
      if (vld_d) dat_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_dat_i : mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         vld_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
         dat_q    <= dat_d;
      end
   end

   assign full_o  = (cnt_q == CNT_FULL);
   assign empty_o = (cnt_q == '0);
   assign vld_o   = vld_q;
   assign dat_o   = dat_q;

endmodule

// File: rtl/lcd_8080_receiver.sv
// 8080 write-bus receiver: synchronizes the bus, decodes writes into {is_cmd,d} records, tracks the address window and RAMWR pixels.
// Latency: record valid SYNC_STAGES+2 clk after the wrx pin rises; window/pixel state updates on the same cycle.
// Backpressure: rec_valid/rec_ready; when the FIFO is full new records are dropped (sticky overflow), the parser still advances.
// Ports: clk, reset; bus (8080 pins + record stream, slave side); clear; col/page window, pixel_count, frame_done, overflow, lcd_in_reset.
module lcd_8080_receiver
   import lcd_8080_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   lcd_8080_receiver_if.slave  bus,
   input  logic                clear,
   output logic [15:0]         col_start,
   output logic [15:0]         col_end,
   output logic [15:0]         page_start,
   output logic [15:0]         page_end,
   output logic [31:0]         pixel_count,
   output logic                frame_done,
   output logic                overflow,
   output logic                lcd_in_reset
);

   // ---------------- input synchronizers ----------------
   logic [SYNC_STAGES-1:0] csx_sync_q, dcx_sync_q, wrx_sync_q, resx_sync_q;
   logic [15:0]            d_sync_q [SYNC_STAGES];
   logic                   s_csx, s_dcx, s_wrx, s_resx;
   logic [15:0]            s_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         csx_sync_q  <= '1;
         wrx_sync_q  <= '1;
         resx_sync_q <= '1;
         dcx_sync_q  <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) d_sync_q[i] <= '0;
      end else begin
         csx_sync_q  <= {csx_sync_q[SYNC_STAGES-2:0],  bus.lcd_csx};
         wrx_sync_q  <= {wrx_sync_q[SYNC_STAGES-2:0],  bus.lcd_wrx};
         resx_sync_q <= {resx_sync_q[SYNC_STAGES-2:0], bus.lcd_resx};
         dcx_sync_q  <= {dcx_sync_q[SYNC_STAGES-2:0],  bus.lcd_dcx};
         d_sync_q[0] <= bus.lcd_d;
         for (int i = 1; i < SYNC_STAGES; i++) d_sync_q[i] <= d_sync_q[i-1];
      end
   end

   assign s_csx  = csx_sync_q[SYNC_STAGES-1];
   assign s_dcx  = dcx_sync_q[SYNC_STAGES-1];
   assign s_wrx  = wrx_sync_q[SYNC_STAGES-1];
   assign s_resx = resx_sync_q[SYNC_STAGES-1];
   assign s_d    = d_sync_q[SYNC_STAGES-1];

   // ---------------- strobe detection ----------------
   logic        wrx_prev_q;
   logic        strobe;
   logic        wr_evt_q, wr_cmd_q;
   logic [15:0] wr_dat_q;

   // Writes are ignored while the panel is held in reset.
   assign strobe = s_wrx && !wrx_prev_q && !s_csx && s_resx;

   always_ff @(posedge clk) begin
      if (reset) begin
         wrx_prev_q <= 1'b1;
         wr_evt_q   <= 1'b0;
         wr_cmd_q   <= 1'b0;
         wr_dat_q   <= '0;
      end else begin
         wrx_prev_q <= s_wrx;
         wr_evt_q   <= strobe;
         if (strobe) begin
            wr_cmd_q <= !s_dcx;
            wr_dat_q <= s_d;
         end
      end
   end

   // ---------------- record FIFO ----------------
   logic fifo_full, fifo_empty, fifo_pop, drop;

   assign fifo_pop = bus.rec_ready && !fifo_empty;
   assign drop     = wr_evt_q && fifo_full && !fifo_pop;

   lcd_rec_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (wr_evt_q),
      .push_dat_i ({wr_cmd_q, wr_dat_q}),
      .pop_i      (fifo_pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .vld_o      (bus.rec_valid),
      .dat_o      (bus.rec_data)
   );

   // ---------------- parser ----------------
   parse_state_e state_q, state_d;
   logic [7:0]   op_q, op_d;
   logic [1:0]   idx_q, idx_d;
   logic [7:0]   start_hi_q, start_hi_d, start_lo_q, start_lo_d, end_hi_q, end_hi_d;
   logic [15:0]  col_start_q, col_start_d, col_end_q, col_end_d;
   logic [15:0]  page_start_q, page_start_d, page_end_q, page_end_d;
   logic [31:0]  pix_q, pix_d, pix_inc, size_q, size_d;
   logic         fd_q, fd_d, ovf_q, ovf_d;

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      idx_d        = idx_q;
      start_hi_d   = start_hi_q;
      start_lo_d   = start_lo_q;
      end_hi_d     = end_hi_q;
      col_start_d  = col_start_q;
      col_end_d    = col_end_q;
      page_start_d = page_start_q;
      page_end_d   = page_end_q;
      pix_d        = pix_q;
      size_d       = size_q;
      fd_d         = 1'b0;
      pix_inc      = (pix_q == '1) ? pix_q : pix_q + 32'd1;

      if (!s_resx) begin
         state_d      = ST_IDLE;
         idx_d        = '0;
         col_start_d  = DEF_COL_START;
         col_end_d    = DEF_COL_END;
         page_start_d = DEF_PAGE_START;
         page_end_d   = DEF_PAGE_END;
         pix_d        = '0;
      end else if (wr_evt_q) begin
         if (wr_cmd_q) begin
            op_d  = wr_dat_q[7:0];
            idx_d = '0;
            case (wr_dat_q[7:0])
               CMD_CASET, CMD_PASET: state_d = ST_PARAM;
               CMD_RAMWR: begin
                  state_d = ST_PIXELS;
                  pix_d   = '0;
                  // Window area captured once per RAMWR; truncation to 32 bits
                  // makes a full 65536x65536 window read as size 0.
                  size_d  = {15'd0, span_len(col_start_q, col_end_q)} *
                            {15'd0, span_len(page_start_q, page_end_q)};
               end
               default: state_d = ST_IDLE;
            endcase
         end else begin
            case (state_q)
               ST_PARAM: begin
                  idx_d = idx_q + 2'd1;
                  case (idx_q)
                     2'd0: start_hi_d = wr_dat_q[7:0];
                     2'd1: start_lo_d = wr_dat_q[7:0];
                     2'd2: end_hi_d   = wr_dat_q[7:0];
                     default: begin
                        state_d = ST_IDLE;
                        if (op_q == CMD_CASET) begin
                           col_start_d = {start_hi_q, start_lo_q};
                           col_end_d   = {end_hi_q, wr_dat_q[7:0]};
                        end else begin
                           page_start_d = {start_hi_q, start_lo_q};
                           page_end_d   = {end_hi_q, wr_dat_q[7:0]};
                        end
                     end
                  endcase
               end
               ST_PIXELS: begin
                  if ((size_q != '0) && (pix_inc == size_q)) begin
                     pix_d = '0;
                     fd_d  = 1'b1;
                  end else begin
                     pix_d = pix_inc;
                  end
               end
               default: ;
            endcase
         end
      end

      if (clear) begin
         pix_d = '0;
         fd_d  = 1'b0;
      end

      // A drop in the same cycle as clear stays visible.
      ovf_d = ovf_q;
      if (clear) ovf_d = 1'b0;
      if (drop)  ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         idx_q        <= '0;
         start_hi_q   <= '0;
         start_lo_q   <= '0;
         end_hi_q     <= '0;
         col_start_q  <= DEF_COL_START;
         col_end_q    <= DEF_COL_END;
         page_start_q <= DEF_PAGE_START;
         page_end_q   <= DEF_PAGE_END;
         pix_q        <= '0;
         size_q       <= '0;
         fd_q         <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         idx_q        <= idx_d;
         start_hi_q   <= start_hi_d;
         start_lo_q   <= start_lo_d;
         end_hi_q     <= end_hi_d;
         col_start_q  <= col_start_d;
         col_end_q    <= col_end_d;
         page_start_q <= page_start_d;
         page_end_q   <= page_end_d;
         pix_q        <= pix_d;
         size_q       <= size_d;
         fd_q         <= fd_d;
         ovf_q        <= ovf_d;
      end
   end

   assign col_start    = col_start_q;
   assign col_end      = col_end_q;
   assign page_start   = page_start_q;
   assign page_end     = page_end_q;
   assign pixel_count  = pix_q;
   assign frame_done   = fd_q;
   assign overflow     = ovf_q;
   assign lcd_in_reset = !s_resx;

endmodule

// File: doc/lcd_8080_receiver.md
Name: lcd_8080_receiver

Overview:
- Receiving end of the 16-bit 8080-style LCD write bus (csx, dcx, d, resx, wrx) driven by the LCD controller component.
- Samples the bus in the system clock domain and decodes each write strobe into a command or data record.
- Tracks the column/page address window and counts RAMWR pixels.
- Serves as an in-system bus monitor (loopback on spare GPIO) and as the display model for the controller's testbench.

Parameters:
- FIFO_DEPTH, 16, record FIFO depth in entries; power of two, minimum 4.
- SYNC_STAGES, 2, synchronizer flops on every bus input; minimum 2.

Ports:
- clk  in  1  system clock; must be at least 4x the wrx toggle rate.
- reset  in  1  synchronous, active-high reset.
- lcd_csx  in  1  chip select, active low.
- lcd_dcx  in  1  0 = command, 1 = data/parameter.
- lcd_wrx  in  1  write strobe; data is latched on its rising edge.
- lcd_d  in  16  bus data.
- lcd_resx  in  1  display reset, active low.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts the record.
- rec_data  out  17  {is_cmd, d[15:0]}.
- col_start, col_end, page_start, page_end  out  16 each  current address window.
- pixel_count  out  32  RAMWR data words since the last 0x2C.
- frame_done  out  1  one-cycle pulse when a full window has been written.
- overflow  out  1  sticky; a record was dropped because the FIFO was full.
- clear  in  1  clears overflow and pixel_count.
- lcd_in_reset  out  1  high while the synchronized resx is low.

Behaviour:
- Inputs and reset:
  - All bus inputs, including lcd_d, pass through SYNC_STAGES flops; lcd_d is delayed identically, so it stays aligned with wrx.
  - The transmitter must hold d and dcx for at least SYNC_STAGES+1 clk after wrx rises. This is a documented constraint; it is not checked.
  - Reset values: all outputs 0; window registers col_end = 239 and page_end = 319 (the panel default); parser state IDLE; FIFO empty; synchronizers load 1 for csx, wrx and resx.
- Strobe detection: a write is a rising edge on the synchronized wrx (previous 0, current 1) while the synchronized csx = 0. A rising edge while csx = 1 is ignored.
- Record path:
  - Each write pushes {~dcx, d} into the FIFO on the cycle after detection.
  - rec_valid rises 1 cycle later, i.e. at most SYNC_STAGES+2 clk after the wrx pin edge.
  - Valid/ready: a pop occurs when rec_valid && rec_ready. rec_data is stable while valid and not ready.
  - FIFO full and a push arrives: the record is dropped and overflow is set. A simultaneous push and pop when full is accepted, with no drop.
- Parser FSM (states IDLE, PARAM, PIXELS), advanced by every write regardless of FIFO space:
  - Command write (dcx = 0) from any state latches the opcode and resets param_idx to 0.
    - 0x2A or 0x2B go to PARAM.
    - 0x2C goes to PIXELS and zeroes pixel_count.
    - Any other opcode goes to IDLE.
  - PARAM: data writes take d[7:0] in order: start high, start low, end high, end low.
    - Opcode 0x2A writes col_start/col_end; opcode 0x2B writes page_start/page_end.
    - The register updates on the 4th byte; after that, go to IDLE. Extra parameters are ignored.
  - PIXELS: each data write increments pixel_count, saturating at 2^32-1.
    - When pixel_count reaches (col_end-col_start+1)*(page_end-page_start+1), frame_done pulses for one cycle and the count restarts at 0. The FSM stays in PIXELS, so streaming continues.
    - The product is an unsigned 17x17 -> 32-bit multiply, registered when entering PIXELS.
    - If end < start, the window size is 0 and frame_done never fires.
  - IDLE: data writes produce records only.
- resx low (synchronized):
  - Parser returns to IDLE, window returns to its default, pixel_count goes to 0, and lcd_in_reset = 1.
  - Writes are ignored and the FIFO is kept.
- Priority rules:
  - clear in the same cycle as a pixel increment: clear wins, and pixel_count = 0.
  - reset mid-burst: everything returns to reset values within 1 cycle; partial parameters are discarded.

Decomposition:
- Package lcd_8080_pkg:
  - opcode constants CMD_CASET = 0x2A, CMD_PASET = 0x2B, CMD_RAMWR = 0x2C;
  - parser state enum;
  - default window constants;
  - record width constant (17).
- Sub-module lcd_rec_fifo: synchronous FIFO with parameterised width/depth, full/empty flags and registered outputs; instantiated once.

Test Plan:
- Write cmd 0x2A, then data 0x00,0x10,0x00,0x1F -> col_start = 16, col_end = 31; 5 records, first = 0x1002A, then 0x00000, 0x00010, 0x00000, 0x0001F.
- CASET 0..1, PASET 0..1, RAMWR + 4 data words -> pixel_count goes 1, 2, 3, then 0 on the 4th word, with frame_done pulsing exactly once on that cycle.
- wrx toggled with csx = 1 -> no records, pixel_count unchanged.
- rec_ready held 0, 20 writes with FIFO_DEPTH = 16 -> 16 records retained in order, overflow = 1; clear -> overflow = 0.
- resx pulled low during PASET after 2 parameters -> page_end = 319, FSM IDLE, lcd_in_reset = 1; a later 0x2C burst counts from 0.
- Back-to-back writes at the minimum spacing of 4 clk, with rec_ready = 1 -> each record is valid no later than 4 clk after its wrx edge, with no drops.
